// File: rtl/stream_bit_packer.sv
// Stream bit packer: keeps the low bitwidth_d bits of each input value and
// packs them LSB-first into OUTPUT_BITWIDTH-wide words. The last word of a
// frame is zero-padded and flagged with trm_last.
module stream_bit_packer #(
  parameter int MAXBITWIDTH     = 16,
  parameter int OUTPUT_BITWIDTH = 32,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [$clog2(MAXBITWIDTH+1)-1:0]   bitwidth_d,
  input  logic [COUNT_WIDTH-1:0]             num_of_values,
  input  logic                               abort,
  input  logic                               rcv_valid,
  input  logic [MAXBITWIDTH-1:0]             rcv_data,
  output logic                               rcv_ready,
  output logic                               trm_valid,
  output logic [OUTPUT_BITWIDTH-1:0]         trm_data,
  output logic                               trm_last,
  input  logic                               trm_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               cfg_err
);

  localparam int BW_W   = $clog2(MAXBITWIDTH + 1);
  localparam int ACC_W  = OUTPUT_BITWIDTH + MAXBITWIDTH;
  localparam int FILL_W = $clog2(OUTPUT_BITWIDTH + MAXBITWIDTH + 1);

  localparam logic [BW_W-1:0]   MAX_BW = BW_W'(MAXBITWIDTH);
  localparam logic [FILL_W-1:0] OBW_F  = FILL_W'(OUTPUT_BITWIDTH);

  if (OUTPUT_BITWIDTH < MAXBITWIDTH) begin : g_param_check
    $error("stream_bit_packer: OUTPUT_BITWIDTH must be >= MAXBITWIDTH");
  end

  typedef enum logic [1:0] {IDLE, PACK, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q;
  logic [FILL_W-1:0]        fill_q;
  logic [COUNT_WIDTH-1:0]   remaining_q;
  logic [BW_W-1:0]          bw_q;
  logic                     cfg_err_q;

  logic                     cfg_legal;
  logic                     rem_zero;
  logic                     rcv_fire;
  logic                     trm_fire;
  logic [ACC_W-1:0]         acc_shift;
  logic [FILL_W-1:0]        fill_shift;
  logic [MAXBITWIDTH-1:0]   data_masked;
  logic [ACC_W-1:0]         acc_ins;

  assign cfg_legal = (bitwidth_d != '0) && (bitwidth_d <= MAX_BW);
  assign rem_zero  = (remaining_q == '0);
  assign rcv_fire  = rcv_valid && rcv_ready;
  assign trm_fire  = trm_valid && trm_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort wins over any handshake in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start && cfg_legal) begin
          state_d = (num_of_values == '0) ? DONE : PACK;
        end
      end
      PACK: begin
        if (abort)                      state_d = IDLE;
        else if (trm_fire && trm_last)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshakes, padded output word and status flags
  always_comb begin
    rcv_ready = (state_q == PACK) && !rem_zero && ((fill_q < OBW_F) || trm_ready);
    trm_valid = (state_q == PACK) &&
                ((fill_q >= OBW_F) || (rem_zero && (fill_q != '0)));
    trm_last  = trm_valid && rem_zero && (fill_q <= OBW_F);
    trm_data  = acc_q[OUTPUT_BITWIDTH-1:0];
    if (fill_q < OBW_F) begin
      trm_data = acc_q[OUTPUT_BITWIDTH-1:0] & ~({OUTPUT_BITWIDTH{1'b1}} << fill_q);
    end
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    cfg_err = cfg_err_q;
  end

  // Datapath next values: drain a word first, then insert the new value above it
  always_comb begin
    acc_shift  = acc_q;
    fill_shift = fill_q;
    if (trm_fire) begin
      acc_shift  = acc_q >> OUTPUT_BITWIDTH;
      fill_shift = (fill_q >= OBW_F) ? (fill_q - OBW_F) : '0;
    end
    data_masked = rcv_data & ~({MAXBITWIDTH{1'b1}} << bw_q);
    acc_ins     = acc_shift | ({{OUTPUT_BITWIDTH{1'b0}}, data_masked} << fill_shift);
  end

  // Accumulator, fill level, value counter and latched configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      fill_q      <= '0;
      remaining_q <= '0;
      bw_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && cfg_legal) begin
            bw_q        <= bitwidth_d;
            remaining_q <= num_of_values;
            acc_q       <= '0;
            fill_q      <= '0;
          end
        end
        PACK: begin
          if (abort) begin
            acc_q       <= '0;
            fill_q      <= '0;
            remaining_q <= '0;
          end else if (rcv_fire) begin
            acc_q       <= acc_ins;
            fill_q      <= fill_shift + FILL_W'(bw_q);
            remaining_q <= remaining_q - 1'b1;
          end else if (trm_fire) begin
            acc_q  <= acc_shift;
            fill_q <= fill_shift;
          end
        end
        default: ;
      endcase
    end
  end

  // One-cycle configuration error pulse for an illegal bit width
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= (state_q == IDLE) && start && !cfg_legal;
  end

endmodule

// File: tb/tb_stream_bit_packer.sv
// Directed bench for stream_bit_packer with hand-computed expected words.
module tb_stream_bit_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  bitwidth_d;
  logic [31:0] num_of_values;
  logic        abort;
  logic        rcv_valid;
  logic [15:0] rcv_data;
  logic        rcv_ready;
  logic        trm_valid;
  logic [31:0] trm_data;
  logic        trm_last;
  logic        trm_ready;
  logic        busy;
  logic        done;
  logic        cfg_err;

  stream_bit_packer dut (
    .clk(clk), .rst(rst), .start(start), .bitwidth_d(bitwidth_d),
    .num_of_values(num_of_values), .abort(abort),
    .rcv_valid(rcv_valid), .rcv_data(rcv_data), .rcv_ready(rcv_ready),
    .trm_valid(trm_valid), .trm_data(trm_data), .trm_last(trm_last),
    .trm_ready(trm_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] vals [8];
  logic [31:0] got_data [$];
  logic        got_last [$];
  logic [31:0] exp_data [3];
  logic        exp_last [3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; rcv_valid = 0; rcv_data = '0;
    bitwidth_d = '0; num_of_values = '0; trm_ready = 1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_rcv_ready"}, rcv_ready, 0);
    check({tag, "_trm_valid"}, trm_valid, 0);
    check({tag, "_trm_last"},  trm_last,  0);
    check({tag, "_trm_data"},  trm_data,  0);
    check({tag, "_done"},      done,      0);
    check({tag, "_cfg_err"},   cfg_err,   0);
  endtask

  // Runs one frame from start to the done pulse, collecting output words.
  task automatic run_frame(input int bw, input int n, input int stall_cycles);
    int idx = 0;
    int stall_left = 0;
    bit stalled = 0;
    bit finished = 0;
    logic [31:0] held = '0;
    got_data.delete();
    got_last.delete();
    tick();
    start = 1; bitwidth_d = 5'(bw); num_of_values = 32'(n);
    tick();
    start = 0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      rcv_valid = (idx < n);
      rcv_data  = (idx < n) ? vals[idx] : 16'h0;
      trm_ready = (stall_left == 0);
      #1;
      if (stall_cycles > 0 && !stalled && trm_valid) begin
        stalled = 1; stall_left = stall_cycles; held = trm_data;
        trm_ready = 0;
        #1;
      end
      if (stall_left > 0) begin
        check("stall_rcv_ready", rcv_ready, 0);
        check("stall_trm_valid", trm_valid, 1);
        check("stall_trm_data",  trm_data,  held);
      end
      if (done) begin
        finished = 1;
      end else begin
        if (rcv_valid && rcv_ready) idx++;
        if (trm_valid && trm_ready) begin
          got_data.push_back(trm_data);
          got_last.push_back(trm_last);
        end
      end
      if (stall_left > 0) stall_left--;
      if (!finished) tick();
    end
    rcv_valid = 0;
    check("frame_done_seen", finished, 1);
    check("values_consumed", idx, n);
    tick();
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_words(input string tag, input int n);
    check({tag, "_word_count"}, got_data.size(), n);
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check({tag, "_data"}, got_data[i], exp_data[i]);
      check({tag, "_last"}, got_last[i], exp_last[i]);
    end
  endtask

  initial begin
    int stray_valid;
    int stray_done;
    idle_inputs();
    rst = 1;
    #12;
    check_idle_outputs("reset");
    tick();
    rst = 0;
    tick();
    check_idle_outputs("post_reset");

    // 4-bit values 1..8 fill exactly one word
    for (int i = 0; i < 8; i++) vals[i] = 16'(i + 1);
    run_frame(4, 8, 0);
    exp_data[0] = 32'h87654321; exp_last[0] = 1;
    check_words("bw4", 1);

    // 12-bit values spill over into a padded second word
    vals[0] = 16'h0ABC; vals[1] = 16'h0123; vals[2] = 16'h0456;
    run_frame(12, 3, 0);
    exp_data[0] = 32'h56123ABC; exp_last[0] = 0;
    exp_data[1] = 32'h00000004; exp_last[1] = 1;
    check_words("bw12", 2);

    // 16-bit stream with a 5-cycle backpressure stall on the first word
    for (int i = 0; i < 6; i++) vals[i] = 16'((i + 1) * 16'h1111);
    run_frame(16, 6, 5);
    exp_data[0] = 32'h22221111; exp_last[0] = 0;
    exp_data[1] = 32'h44443333; exp_last[1] = 0;
    exp_data[2] = 32'h66665555; exp_last[2] = 1;
    check_words("bw16_stall", 3);

    // Illegal widths 0 and 17 raise a one-cycle cfg_err and stay idle
    for (int k = 0; k < 2; k++) begin
      tick();
      start = 1; bitwidth_d = (k == 0) ? 5'd0 : 5'd17; num_of_values = 32'd5;
      tick();
      start = 0;
      check("cfg_err_pulse", cfg_err, 1);
      check("cfg_err_busy", busy, 0);
      tick();
      check("cfg_err_clear", cfg_err, 0);
      check("cfg_err_busy_after", busy, 0);
    end

    // Zero-length frame: done pulse, no output word
    tick();
    start = 1; bitwidth_d = 5'd4; num_of_values = 32'd0;
    tick();
    start = 0;
    check("empty_done", done, 1);
    check("empty_trm_valid", trm_valid, 0);
    check("empty_cfg_err", cfg_err, 0);
    tick();
    check("empty_done_clear", done, 0);
    check("empty_busy", busy, 0);

    // Async reset mid-frame after three 8-bit values
    tick();
    start = 1; bitwidth_d = 5'd8; num_of_values = 32'd6;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      rcv_valid = 1; rcv_data = 16'(16'h00A0 + i);
      tick();
    end
    rcv_valid = 0;
    check("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    check_idle_outputs("mid_rst");
    tick();
    rst = 0;
    tick();
    check_idle_outputs("after_rst");
    // High junk bits must be discarded
    vals[0] = 16'hA511; vals[1] = 16'h5A22; vals[2] = 16'hFF33; vals[3] = 16'h0044;
    run_frame(8, 4, 0);
    exp_data[0] = 32'h44332211; exp_last[0] = 1;
    check_words("post_rst", 1);

    // Abort mid-frame; a start pulse during PACK is ignored
    tick();
    start = 1; bitwidth_d = 5'd8; num_of_values = 32'd4;
    tick();
    start = 0; rcv_valid = 1; rcv_data = 16'h0011;
    tick();
    rcv_data = 16'h0022;
    tick();
    rcv_valid = 0; abort = 1; start = 1; bitwidth_d = 5'd3;
    tick();
    abort = 0; start = 0;
    check("abort_busy", busy, 0);
    check("abort_trm_valid", trm_valid, 0);
    check("abort_done", done, 0);
    check("abort_cfg_err", cfg_err, 0);
    stray_valid = 0; stray_done = 0;
    rcv_valid = 1; rcv_data = 16'h0033;
    for (int i = 0; i < 10; i++) begin
      if (trm_valid) stray_valid++;
      if (done) stray_done++;
      if (rcv_ready) stray_valid++;
      tick();
    end
    rcv_valid = 0;
    check("abort_no_activity", stray_valid, 0);
    check("abort_no_done", stray_done, 0);

    // Fresh frame after abort packs from bit 0
    vals[0] = 16'h0055; vals[1] = 16'h0066;
    run_frame(8, 2, 0);
    exp_data[0] = 32'h00006655; exp_last[0] = 1;
    check_words("post_abort", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/stream_bit_packer.md
STREAM_BIT_PACKER -- requirements
Module: stream_bit_packer

Interface
REQ-001 SHALL have parameter MAXBITWIDTH, default 16, maximum input value width in bits.
REQ-002 SHALL have parameter OUTPUT_BITWIDTH, default 32, packed output word width; OUTPUT_BITWIDTH >= MAXBITWIDTH is required (elaboration error otherwise).
REQ-003 SHALL have parameter COUNT_WIDTH, default 32, width of the value counter.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock.
REQ-005 rst input 1: asynchronous active-high reset.
REQ-006 start input 1: one-cycle pulse, latches configuration and begins a frame.
REQ-007 bitwidth_d input $clog2(MAXBITWIDTH+1): bits kept per value, legal range 1..MAXBITWIDTH.
REQ-008 num_of_values input COUNT_WIDTH: number of input values in the frame.
REQ-009 abort input 1: synchronous frame cancel.
REQ-010 rcv_valid input 1; rcv_data input MAXBITWIDTH; rcv_ready output 1: input handshake.
REQ-011 trm_valid output 1; trm_data output OUTPUT_BITWIDTH; trm_last output 1; trm_ready input 1: output handshake.
REQ-012 busy output 1 (state != IDLE); done output 1 (one-cycle pulse); cfg_err output 1 (one-cycle pulse).

Function
REQ-013 SHALL implement FSM states IDLE, PACK, DONE.
REQ-014 IDLE + start + bitwidth_d in 1..MAXBITWIDTH + num_of_values != 0: latch bitwidth and count into internal registers, clear accumulator and fill; go to PACK next cycle.
REQ-015 IDLE + start + num_of_values == 0 (legal bitwidth): go to DONE; no output word.
REQ-016 IDLE + start + bitwidth_d == 0 or > MAXBITWIDTH: assert cfg_err the next cycle for one cycle; remain IDLE.
REQ-017 start outside IDLE SHALL be ignored; latched configuration SHALL NOT change mid-frame.
REQ-018 Accumulator width SHALL be OUTPUT_BITWIDTH+MAXBITWIDTH; fill counter width SHALL be $clog2(OUTPUT_BITWIDTH+MAXBITWIDTH+1).
REQ-019 rcv_ready = (state==PACK) and remaining != 0 and (fill < OUTPUT_BITWIDTH or trm_ready); combinational path from trm_ready is allowed.
REQ-020 Accepted value: low bitwidth bits of rcv_data inserted LSB-first at accumulator bit position fill (after any same-cycle shift); upper rcv_data bits discarded; remaining decrements by 1.
REQ-021 trm_valid = (state==PACK) and (fill >= OUTPUT_BITWIDTH or (remaining==0 and fill>0)).
REQ-022 trm_data = accumulator[OUTPUT_BITWIDTH-1:0], bits at or above fill forced to 0 when fill < OUTPUT_BITWIDTH.
REQ-023 trm_last = trm_valid and remaining==0 and fill <= OUTPUT_BITWIDTH.
REQ-024 On output handshake: accumulator shifts right by OUTPUT_BITWIDTH and fill decreases by min(fill, OUTPUT_BITWIDTH).
REQ-025 Simultaneous input and output handshakes in one cycle SHALL be supported: shift first, then insert at fill-OUTPUT_BITWIDTH; sustained throughput one value per cycle.
REQ-026 trm_data and trm_last SHALL be held stable while trm_valid and not trm_ready.
REQ-027 Output handshake with trm_last SHALL transition PACK -> DONE.
REQ-028 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-029 abort in PACK SHALL return to IDLE next cycle, discard accumulator, and produce no done; abort overrides same-cycle handshakes.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, clear accumulator, fill, remaining and latched config.
REQ-031 During and after reset, until the next start: rcv_ready=0, trm_valid=0, trm_last=0, trm_data=0, busy=0, done=0, cfg_err=0.
REQ-032 Reset asserted mid-frame SHALL discard partial data; no stale word after release.

Verification
REQ-033 Defaults, bitwidth 4, count 8, values 1..8, trm_ready=1 -> single word 0x87654321 with trm_last=1, then done pulse.
REQ-034 Bitwidth 12, count 3, values 0xABC, 0x123, 0x456 -> word 0x56123ABC (last=0), then 0x00000004 (last=1).
REQ-035 Bitwidth 16, continuous input, trm_ready held low 5 cycles after first full word -> rcv_ready=0 while fill>=32, trm_data stable, no data lost after release.
REQ-036 start with bitwidth_d=0, then 17 -> cfg_err pulse each time, busy stays 0; start with count 0 -> done pulse, no trm_valid.
REQ-037 rst pulse mid-frame after 3 values (bitwidth 8) -> all outputs 0 immediately; next frame packs correctly from bit 0.
REQ-038 abort mid-frame -> IDLE next cycle, no done, no further trm_valid.
